// File: rtl/mem_io_bridge_if.sv
// CPU memory-port bundle: address, store data and write strobe from the CPU,
// combinational read data back from the bridge.
interface mem_io_bridge_if;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        MemWrite;
  logic [31:0] readdata;

  modport master (output adr, output writedata, output MemWrite, input readdata);
  modport slave  (input adr, input writedata, input MemWrite, output readdata);
endinterface

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: unified instruction/data RAM plus a memory-mapped IO page
// (LEDs, switches, 7-seg data, compare timer) behind the CPU memory port.
// Reads are combinational; writes commit on the rising clk edge.
// RAM contents are loaded by the bench through hierarchical writes.
module mem_io_bridge #(
  parameter int          RAM_WORDS = 1024,
  parameter logic [15:0] IO_PAGE   = 16'hFFFF,
  parameter string       INIT_FILE = "mem.hex"
) (
  input  logic               clk,
  input  logic               rst,
  mem_io_bridge_if.slave     bus,
  input  logic [15:0]        sw_i,
  output logic [15:0]        led_o,
  output logic [31:0]        seg_o
);
  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  logic          is_io, io_hit;
  logic [5:0]    io_off;

  logic [15:0] led;
  logic [31:0] seg;
  logic [15:0] sw_s1, sw_s2;
  logic [1:0]  tctrl;
  logic [31:0] tcmp, tcnt;
  logic        flag;

  logic wr_ram, wr_led, wr_seg, wr_tctrl, wr_tcmp, wr_tcnt, wr_tstat;
  logic t_en, t_match;

  // Address bits [1:0] are byte lanes; accesses are whole words.
  logic unused_adr;
  assign unused_adr = ^bus.adr[1:0];

  // Upper RAM address bits are dropped so out-of-range addresses wrap.
  assign ram_idx = bus.adr[AW+1:2];
  assign is_io   = (bus.adr[31:16] == IO_PAGE);
  assign io_hit  = is_io && (bus.adr[15:8] == 8'h00);
  assign io_off  = bus.adr[7:2];

  assign wr_ram   = bus.MemWrite && !is_io;
  assign wr_led   = bus.MemWrite && io_hit && (io_off == 6'h00);
  assign wr_seg   = bus.MemWrite && io_hit && (io_off == 6'h02);
  assign wr_tctrl = bus.MemWrite && io_hit && (io_off == 6'h04);
  assign wr_tcmp  = bus.MemWrite && io_hit && (io_off == 6'h05);
  assign wr_tcnt  = bus.MemWrite && io_hit && (io_off == 6'h06);
  assign wr_tstat = bus.MemWrite && io_hit && (io_off == 6'h07);

  assign t_en    = tctrl[0];
  assign t_match = t_en && (tcnt == tcmp);

  localparam string unused_init_file = INIT_FILE;

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ram) ram[ram_idx] <= bus.writedata;
  end

  // IO registers, switch synchroniser and compare timer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      led   <= '0;
      seg   <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
      tctrl <= '0;
      tcmp  <= '0;
      tcnt  <= '0;
      flag  <= 1'b0;
    end else begin
      sw_s1 <= sw_i;
      sw_s2 <= sw_s1;
      if (wr_led)   led   <= bus.writedata[15:0];
      if (wr_seg)   seg   <= bus.writedata;
      if (wr_tctrl) tctrl <= bus.writedata[1:0];
      if (wr_tcmp)  tcmp  <= bus.writedata;
      // A CPU write to TCNT beats both increment and autoreload.
      if (wr_tcnt)                 tcnt <= bus.writedata;
      else if (t_match && tctrl[1]) tcnt <= '0;
      else if (t_en)                tcnt <= tcnt + 32'd1;
      // A fresh match wins over a coincident write-1-to-clear.
      if (t_match)                           flag <= 1'b1;
      else if (wr_tstat && bus.writedata[0]) flag <= 1'b0;
    end
  end

  // Combinational read mux; independent of MemWrite, so a same-cycle
  // read of a word being written returns the old contents.
  always_comb begin
    bus.readdata = '0;
    if (!is_io) begin
      bus.readdata = ram[ram_idx];
    end else if (io_hit) begin
      case (io_off)
        6'h00:   bus.readdata = {16'h0, led};
        6'h01:   bus.readdata = {16'h0, sw_s2};
        6'h02:   bus.readdata = seg;
        6'h04:   bus.readdata = {30'h0, tctrl};
        6'h05:   bus.readdata = tcmp;
        6'h06:   bus.readdata = tcnt;
        6'h07:   bus.readdata = {31'h0, flag};
        default: bus.readdata = '0;
      endcase
    end
  end

  assign led_o = led;
  assign seg_o = seg;
endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: RAM wrap and read-before-write, IO
// registers, switch synchroniser latency, timer autoreload/W1C/override,
// hold when disabled, and reset behaviour.
module tb_mem_io_bridge;
  localparam logic [31:0] LED   = 32'hFFFF_0000;
  localparam logic [31:0] SW    = 32'hFFFF_0004;
  localparam logic [31:0] SEG   = 32'hFFFF_0008;
  localparam logic [31:0] TCTRL = 32'hFFFF_0010;
  localparam logic [31:0] TCMP  = 32'hFFFF_0014;
  localparam logic [31:0] TCNT  = 32'hFFFF_0018;
  localparam logic [31:0] TSTAT = 32'hFFFF_001C;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw_i;
  logic [15:0] led_o;
  logic [31:0] seg_o;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] v;

  mem_io_bridge_if bus ();

  mem_io_bridge #(.RAM_WORDS(1024), .IO_PAGE(16'hFFFF), .INIT_FILE("mem.hex")) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .sw_i  (sw_i),
    .led_o (led_o),
    .seg_o (seg_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.adr = a; bus.writedata = d; bus.MemWrite = 1'b1;
    @(posedge clk); #1;
    bus.MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.adr = a; bus.MemWrite = 1'b0;
    #1 d = bus.readdata;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b0; sw_i = '0;
    bus.adr = '0; bus.writedata = '0; bus.MemWrite = 1'b0;
    tick(2);
    rst = 1'b1;

    // reset state
    chk("rst_led", {16'h0, led_o}, 32'h0);
    chk("rst_seg", seg_o, 32'h0);
    rd(TCNT, v);  chk("rst_tcnt", v, 32'h0);
    rd(TSTAT, v); chk("rst_tstat", v, 32'h0);
    rd(TCTRL, v); chk("rst_tctrl", v, 32'h0);

    // RAM write, wrap, old-value-on-same-cycle read
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, v); chk("ram_rd", v, 32'hDEAD_BEEF);
    rd(32'h0000_1010, v); chk("ram_wrap", v, 32'hDEAD_BEEF);
    bus.adr = 32'h0000_0010; bus.writedata = 32'h1111_1111; bus.MemWrite = 1'b1;
    #1 chk("ram_old", bus.readdata, 32'hDEAD_BEEF);
    @(posedge clk); #1; bus.MemWrite = 1'b0;
    rd(32'h0000_1010, v); chk("ram_new", v, 32'h1111_1111);

    // LED / SW / SEG / unmapped
    wr(LED, 32'h0000_00A5);
    chk("led_o", {16'h0, led_o}, 32'h0000_00A5);
    rd(LED, v); chk("led_rd", v, 32'h0000_00A5);
    sw_i = 16'h1234;
    rd(SW, v); chk("sw_0edge", v, 32'h0);
    tick(1); rd(SW, v); chk("sw_1edge", v, 32'h0);
    tick(1); rd(SW, v); chk("sw_2edge", v, 32'h1234);
    wr(SW, 32'h0000_FFFF);
    rd(SW, v); chk("sw_ro", v, 32'h1234);
    wr(SEG, 32'hCAFE_F00D);
    chk("seg_o", seg_o, 32'hCAFE_F00D);
    wr(32'hFFFF_0100, 32'h0000_0000);
    chk("led_unmap_wr", {16'h0, led_o}, 32'h0000_00A5);
    rd(32'hFFFF_0100, v); chk("unmap_hi", v, 32'h0);
    rd(32'hFFFF_000C, v); chk("unmap_0c", v, 32'h0);

    // timer autoreload: TCMP=5, TCTRL=3
    wr(TCMP, 32'd5);
    wr(TCTRL, 32'd3);
    rd(TCNT, v); chk("t_start", v, 32'd0);
    rd(TCTRL, v); chk("tctrl_rd", v, 32'd3);
    for (int k = 1; k <= 7; k++) begin
      tick(1); rd(TCNT, v);
      chk($sformatf("t_seq%0d", k), v, (k <= 5) ? k : k - 6);
    end
    rd(TSTAT, v); chk("t_flag_set", v, 32'd1);
    wr(TSTAT, 32'd1);                        // TCNT=1 at this edge: no match
    rd(TSTAT, v); chk("t_w1c", v, 32'd0);

    // CPU write to TCNT overrides increment
    wr(TCNT, 32'd100);
    rd(TCNT, v); chk("t_override", v, 32'd100);
    wr(TCNT, 32'd3);
    tick(2);
    rd(TCNT, v); chk("t_at5", v, 32'd5);
    rd(TSTAT, v); chk("t_pre_w1c", v, 32'd0);
    wr(TSTAT, 32'd1);                        // coincides with match
    rd(TSTAT, v); chk("t_set_wins", v, 32'd1);
    rd(TCNT, v); chk("t_reload", v, 32'd0);

    // plain wrap without autoreload
    wr(TCTRL, 32'd1);
    wr(TCNT, 32'hFFFF_FFFF);
    tick(1); rd(TCNT, v); chk("t_wrap", v, 32'd0);

    // disabled: hold; reserved TCTRL bits read 0
    wr(TCTRL, 32'hFFFF_FFFC);                // enable still 1 at this edge: 0->1
    rd(TCTRL, v); chk("tctrl_rsvd", v, 32'd0);
    tick(2); rd(TCNT, v); chk("t_hold", v, 32'd1);

    // reset mid-count
    wr(LED, 32'h0000_FFFF);
    wr(TCTRL, 32'd1);
    tick(3);
    rd(TSTAT, v); chk("pre_rst_flag", v, 32'd1);
    rst = 1'b0; tick(1); rst = 1'b1;
    chk("rst2_led", {16'h0, led_o}, 32'h0);
    chk("rst2_seg", seg_o, 32'h0);
    rd(TCNT, v);  chk("rst2_tcnt", v, 32'h0);
    rd(TSTAT, v); chk("rst2_tstat", v, 32'h0);
    tick(2); rd(TCNT, v); chk("rst2_stopped", v, 32'h0);
    rd(32'h0000_0010, v); chk("rst2_ram", v, 32'h1111_1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
